// File: rtl/sseg_scan.sv
// rtl/sseg_scan.sv - eight-digit multiplexed seven-segment scan driver with per-frame snapshot
module sseg_scan #(
    parameter int CLK_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data,
    input  logic [7:0]  dp_mask,
    input  logic        blank_lz,
    output logic [7:0]  SSEG_AN,
    output logic [7:0]  SSEG_CA,
    output logic        frame_done
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          fresh;
    logic [31:0]   shadow_data;
    logic [7:0]    shadow_dp;
    logic          shadow_blank;

    logic          wrap;
    logic          snap;
    logic [3:0]    nibble;
    logic [6:0]    hex_seg;
    logic          blanked;

    // Active-low hex glyphs, bit order g..a
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign wrap = (cnt == CW'(CLK_DIV - 1));
    // A new frame starts right after reset or when the last digit's slot expires
    assign snap = fresh || (wrap && (idx == 3'd7));

    // Digit dwell counter and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (wrap) begin
            cnt <= '0;
            idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Frame snapshot so a frame never mixes two input values
    always_ff @(posedge clk) begin
        if (rst) begin
            fresh        <= 1'b1;
            shadow_data  <= 32'd0;
            shadow_dp    <= 8'd0;
            shadow_blank <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            fresh      <= 1'b0;
            frame_done <= snap;
            if (snap) begin
                shadow_data  <= data;
                shadow_dp    <= dp_mask;
                shadow_blank <= blank_lz;
            end
        end
    end

    // Current digit glyph and leading-zero decision; digit 0 always shows
    always_comb begin
        nibble  = shadow_data[{idx, 2'b00} +: 4];
        hex_seg = hex_to_seg(nibble);
        blanked = shadow_blank && (idx != 3'd0) &&
                  ((shadow_data >> {idx, 2'b00}) == 32'd0);
    end

    // Registered anode/segment drive, one cycle behind idx
    always_ff @(posedge clk) begin
        if (rst) begin
            SSEG_AN <= 8'hFF;
            SSEG_CA <= 8'hFF;
        end else if (blanked) begin
            SSEG_AN <= 8'hFF;
            SSEG_CA <= 8'hFF;
        end else begin
            SSEG_AN <= ~(8'd1 << idx);
            SSEG_CA <= {~shadow_dp[idx], hex_seg};
        end
    end

endmodule

// File: tb/tb_sseg_scan.sv
// tb/tb_sseg_scan.sv - directed and randomized check of sseg_scan against a frame-level model
module tb_sseg_scan;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data = 32'd0;
    logic [7:0]  dp_mask = 8'd0;
    logic        blank_lz = 1'b0;
    logic [7:0]  SSEG_AN;
    logic [7:0]  SSEG_CA;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;

    int          k = 0;
    logic [31:0] sh_data = 32'd0;
    logic [7:0]  sh_dp = 8'd0;
    logic        sh_blank = 1'b0;
    logic [6:0]  hex_tab [16];

    sseg_scan #(.CLK_DIV(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp_mask    (dp_mask),
        .blank_lz   (blank_lz),
        .SSEG_AN    (SSEG_AN),
        .SSEG_CA    (SSEG_CA),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, got, exp);
        end
    endtask

    // One clock: capture the inputs seen at the edge, advance the model, compare
    task automatic tick();
        logic        r;
        logic [31:0] d;
        logic [7:0]  m;
        logic        b;
        int          ip;
        logic [31:0] upper;
        logic        blk;
        logic [7:0]  ea;
        logic [7:0]  ec;
        logic        snap_edge;
        r = rst; d = data; m = dp_mask; b = blank_lz;
        @(posedge clk);
        #1;
        if (r) begin
            k = 0;
            sh_data = 32'd0; sh_dp = 8'd0; sh_blank = 1'b0;
            ea = 8'hFF; ec = 8'hFF; snap_edge = 1'b0;
        end else begin
            k++;
            ip = ((k - 1) / D) % 8;
            upper = sh_data >> (4 * ip);
            blk = sh_blank && (ip > 0) && (upper == 32'd0);
            if (blk) begin
                ea = 8'hFF;
                ec = 8'hFF;
            end else begin
                ea = 8'hFF ^ (8'h01 << ip);
                ec = {~sh_dp[ip], hex_tab[int'(upper & 32'hF)]};
            end
            snap_edge = (k == 1) || (k % (8 * D) == 0);
            if (snap_edge) begin
                sh_data = d; sh_dp = m; sh_blank = b;
            end
        end
        check8("an", SSEG_AN, ea);
        check8("ca", SSEG_CA, ec);
        check8("frame_done", {7'd0, frame_done}, {7'd0, snap_edge});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Reset held two cycles, then release with zero data
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(8 * D + 4);

        // Full hex decode
        data = 32'hFEDC_BA98;
        run(2 * 8 * D);

        // Snapshot isolation: change data in the middle of a frame
        data = 32'h1234_5678;
        run(8 * D);
        run(3 * D + 1);
        data = 32'hFFFF_FFFF;
        run(2 * 8 * D);

        // Leading-zero blanking
        blank_lz = 1'b1;
        data = 32'h0000_00A5;
        run(2 * 8 * D);
        data = 32'h0000_0000;
        run(2 * 8 * D);
        blank_lz = 1'b0;
        run(2 * 8 * D);

        // Decimal points, then a blanked digit suppresses its point
        dp_mask = 8'h05;
        data = 32'h1111_1111;
        run(2 * 8 * D);
        blank_lz = 1'b1;
        data = 32'h0000_0001;
        run(2 * 8 * D);

        // Mid-frame reset at digit 5
        rst = 1'b1;
        tick();
        rst = 1'b0;
        data = 32'h0BAD_CAFE;
        run(5 * D + 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(2 * 8 * D);

        // Randomized input changes at arbitrary times, occasional resets
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 3))
                0: data = $urandom;
                1: data = $urandom >> (4 * $urandom_range(1, 7));
                2: data = 32'd0;
                default: data = $urandom & 32'h0000_0F0F;
            endcase
            dp_mask  = 8'($urandom_range(0, 255));
            blank_lz = 1'($urandom_range(0, 1));
            rst      = ($urandom_range(0, 19) == 0);
            tick();
            rst = 1'b0;
            run($urandom_range(1, 40));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
